ps2_scancode_decoder: RTL and testbench

- Sits directly downstream of the PS2 controller and consumes its `received_data` / `received_data_en` byte stream.
- Assembles Set-2 keyboard scan-code sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single key events.
- Buffers key events in a small FIFO behind a valid/ready handshake.
- Tracks modifier-held state and discards device response bytes (FA, AA, EE, FE, FC, 00, FF).

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_event_fifo.sv | 63 ++++++
 rtl/ps2_scancode_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SKIP_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    localparam logic [BYTE_W-1:0] PFX_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] PFX_BRK   = 8'hF0;
    localparam logic [BYTE_W-1:0] PFX_PAUSE = 8'hE1;
    localparam logic [BYTE_W-1:0] LSHIFT    = 8'h12;
    localparam logic [BYTE_W-1:0] RSHIFT    = 8'h59;
    localparam logic [BYTE_W-1:0] CTRL      = 8'h14;
    localparam logic [BYTE_W-1:0] ALT       = 8'h11;
    localparam logic [BYTE_W-1:0] MAX_MAKE  = 8'h83;

    // Bytes that follow E1 in the Pause sequence (E1 14 77 E1 F0 14 F0 77)
    localparam logic [SKIP_W-1:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic              ext;
        logic              rel;
    } key_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO of key events; a pop in the same cycle lets a
// push into a full FIFO succeed.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  key_event_t wdata,
    input  logic       pop,
    output key_event_t rdata,
    output logic       valid,
    output logic       full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    key_event_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    // Handshake qualification and next occupancy
    always_comb begin
        do_pop    = pop && valid;
        do_push   = push && (!full || do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // Storage, pointers and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            valid <= (count_nxt != '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code sequence assembler: turns the PS/2 byte stream into key
// events, tracks held modifiers and drops device response bytes.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeated makes.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [BYTE_W-1:0] received_data,
    input  logic              received_data_en,
    input  logic              event_ready,
    output logic              event_valid,
    output logic [BYTE_W-1:0] event_code,
    output logic              event_extended,
    output logic              event_released,
    output logic              shift_held,
    output logic              ctrl_held,
    output logic              alt_held,
    output logic              overflow,
    output logic              resp_byte_seen
);

    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned MOD_W = 6;

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              dec_emit;
    key_event_t        dec_ev;
    logic              suppress;
    logic              push;
    key_event_t        push_ev;
    key_event_t        head_ev;
    logic              fifo_full;
    logic [MOD_W-1:0]  mod_q;
    logic [MOD_W-1:0]  mod_nxt;

    // Event completed by the byte strobed this cycle, if any
    always_comb begin
        dec_emit = 1'b0;
        dec_ev   = '0;
        if (received_data_en) begin
            case (state)
                S_IDLE: begin
                    if (received_data >= 8'h01 && received_data <= MAX_MAKE) begin
                        dec_emit = 1'b1;
                        dec_ev   = '{code: received_data, ext: 1'b0, rel: 1'b0};
                    end
                end
                S_EXT: begin
                    if (received_data != PFX_BRK) begin
                        dec_emit = 1'b1;
                        dec_ev   = '{code: received_data, ext: 1'b1, rel: 1'b0};
                    end
                end
                S_BRK: begin
                    dec_emit = 1'b1;
                    dec_ev   = '{code: received_data, ext: 1'b0, rel: 1'b1};
                end
                S_EXT_BRK: begin
                    dec_emit = 1'b1;
                    dec_ev   = '{code: received_data, ext: 1'b1, rel: 1'b1};
                end
                S_PAUSE: begin
                    if (skip_cnt == SKIP_W'(1)) begin
                        dec_emit = 1'b1;
                        dec_ev   = '{code: PFX_PAUSE, ext: 1'b1, rel: 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [BYTE_W:0] last_key;
    logic            last_vld;

    // A make identical to the last one is an auto-repeat and is dropped
    always_comb begin
        suppress = dec_emit && !dec_ev.rel && last_vld &&
                   (last_key == {dec_ev.code, dec_ev.ext});
    end

    // Remember the most recent make; its own break forgets it
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            last_key <= '0;
            last_vld <= 1'b0;
        end else if (dec_emit) begin
            if (!dec_ev.rel) begin
                last_key <= {dec_ev.code, dec_ev.ext};
                last_vld <= 1'b1;
            end else if (last_vld && last_key == {dec_ev.code, dec_ev.ext}) begin
                last_vld <= 1'b0;
            end
        end
    end
`else
    // Every make is forwarded, auto-repeats included
    always_comb begin
        suppress = 1'b0;
    end
`endif

    // Sequence FSM with inter-byte timeout and registered push request
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            skip_cnt       <= '0;
            to_cnt         <= '0;
            push           <= 1'b0;
            push_ev        <= '0;
            resp_byte_seen <= 1'b0;
        end else begin
            push           <= dec_emit && !suppress;
            push_ev        <= dec_ev;
            resp_byte_seen <= 1'b0;
            if (received_data_en) begin
                to_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (received_data == PFX_EXT) begin
                            state <= S_EXT;
                        end else if (received_data == PFX_BRK) begin
                            state <= S_BRK;
                        end else if (received_data == PFX_PAUSE) begin
                            state    <= S_PAUSE;
                            skip_cnt <= PAUSE_SKIP;
                        end else if (!dec_emit) begin
                            resp_byte_seen <= 1'b1;
                        end
                    end
                    S_EXT:     state <= (received_data == PFX_BRK) ? S_EXT_BRK : S_IDLE;
                    S_BRK:     state <= S_IDLE;
                    S_EXT_BRK: state <= S_IDLE;
                    S_PAUSE: begin
                        skip_cnt <= skip_cnt - SKIP_W'(1);
                        if (skip_cnt == SKIP_W'(1)) begin
                            state <= S_IDLE;
                        end
                    end
                    default:   state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state  <= S_IDLE;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

    // Per-side modifier bits: {ralt, lalt, rctrl, lctrl, rshift, lshift}
    always_comb begin
        mod_nxt = mod_q;
        if (push) begin
            case ({push_ev.ext, push_ev.code})
                {1'b0, LSHIFT}: mod_nxt[0] = !push_ev.rel;
                {1'b0, RSHIFT}: mod_nxt[1] = !push_ev.rel;
                {1'b0, CTRL}:   mod_nxt[2] = !push_ev.rel;
                {1'b1, CTRL}:   mod_nxt[3] = !push_ev.rel;
                {1'b0, ALT}:    mod_nxt[4] = !push_ev.rel;
                {1'b1, ALT}:    mod_nxt[5] = !push_ev.rel;
                default: ;
            endcase
        end
    end

    // Modifier flags and sticky overflow
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            mod_q      <= '0;
            shift_held <= 1'b0;
            ctrl_held  <= 1'b0;
            alt_held   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            mod_q      <= mod_nxt;
            shift_held <= mod_nxt[0] | mod_nxt[1];
            ctrl_held  <= mod_nxt[2] | mod_nxt[3];
            alt_held   <= mod_nxt[4] | mod_nxt[5];
            if (push && fifo_full && !(event_valid && event_ready)) begin
                overflow <= 1'b1;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .push  (push),
        .wdata (push_ev),
        .pop   (event_ready),
        .rdata (head_ev),
        .valid (event_valid),
        .full  (fifo_full)
    );

    assign event_code     = head_ev.code;
    assign event_extended = head_ev.ext;
    assign event_released = head_ev.rel;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events are queued as
// bytes are driven and compared as the consumer accepts them.
module tb_ps2_scancode_decoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en = 1'b0;
    logic       ready = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic       shift_h;
    logic       ctrl_h;
    logic       alt_h;
    logic       ovf;
    logic       resp;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb [$];
    logic [9:0] mon_got;
    logic [9:0] mon_exp;

    always #10 clk = ~clk;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (rst_n),
        .received_data    (rx_data),
        .received_data_en (rx_en),
        .event_ready      (ready),
        .event_valid      (ev_valid),
        .event_code       (ev_code),
        .event_extended   (ev_ext),
        .event_released   (ev_rel),
        .shift_held       (shift_h),
        .ctrl_held        (ctrl_h),
        .alt_held         (alt_h),
        .overflow         (ovf),
        .resp_byte_seen   (resp)
    );

    // Consumer side: every accepted event must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && ev_valid && ready) begin
            mon_got = {ev_code, ev_ext, ev_rel};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got {code,ext,rel}=%h_%b_%b, none expected",
                         mon_got[9:2], mon_got[1], mon_got[0]);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL event_order got %h_%b_%b expected %h_%b_%b",
                             mon_got[9:2], mon_got[1], mon_got[0],
                             mon_exp[9:2], mon_exp[1], mon_exp[0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_en   = 1'b1;
        @(posedge clk); #1;
        rx_en   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel);
        sb.push_back({code, ext, rel});
    endtask

    // Let the consumer empty the FIFO, bounded
    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 60 && (sb.size() != 0 || ev_valid); i++) begin
            @(posedge clk);
        end
        cycles(3);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_rel, shift_h, ctrl_h, alt_h, ovf, resp} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0000",
                     {ev_valid, ev_code, ev_ext, ev_rel, shift_h, ctrl_h, alt_h, ovf, resp});
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_make_break();
        ready = 1'b0;
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL mk_latency_early got valid=%b required 0", ev_valid);
        end
        cycles(1);
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_rel} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mk_present got %b_%h_%b_%b required 1_1c_0_0",
                               ev_valid, ev_code, ev_ext, ev_rel);
        end
        ready = 1'b1;
        cycles(2);
        ready = 1'b0;
        expect_ev(8'h1C, 1'b0, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL brk_latency_early got valid=%b required 0", ev_valid);
        end
        cycles(1);
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_rel} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
            errors++; $display("FAIL brk_present got %b_%h_%b_%b required 1_1c_0_1",
                               ev_valid, ev_code, ev_ext, ev_rel);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL make_break_missing got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_modifiers();
        ready = 1'b1;
        expect_ev(8'h14, 1'b1, 1'b0);
        send_byte(8'hE0); send_byte(8'h14);
        cycles(2);
        checks++;
        if (ctrl_h !== 1'b1) begin
            errors++; $display("FAIL rctrl_make got ctrl=%b required 1", ctrl_h);
        end
        expect_ev(8'h14, 1'b1, 1'b1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        cycles(2);
        checks++;
        if (ctrl_h !== 1'b0) begin
            errors++; $display("FAIL rctrl_break got ctrl=%b required 0", ctrl_h);
        end
        expect_ev(8'h12, 1'b0, 1'b0); send_byte(8'h12);
        expect_ev(8'h59, 1'b0, 1'b0); send_byte(8'h59);
        expect_ev(8'h12, 1'b0, 1'b1); send_byte(8'hF0); send_byte(8'h12);
        cycles(2);
        checks++;
        if (shift_h !== 1'b1) begin
            errors++; $display("FAIL shift_or got shift=%b required 1", shift_h);
        end
        expect_ev(8'h59, 1'b0, 1'b1); send_byte(8'hF0); send_byte(8'h59);
        cycles(2);
        checks++;
        if (shift_h !== 1'b0) begin
            errors++; $display("FAIL shift_release got shift=%b required 0", shift_h);
        end
        expect_ev(8'h11, 1'b1, 1'b0); send_byte(8'hE0); send_byte(8'h11);
        cycles(2);
        checks++;
        if (alt_h !== 1'b1) begin
            errors++; $display("FAIL ralt_make got alt=%b required 1", alt_h);
        end
        expect_ev(8'h11, 1'b1, 1'b1); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h11);
        drain();
        checks++;
        if (alt_h !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL ralt_break got alt=%b pending=%0d required 0/0", alt_h, sb.size());
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        ready = 1'b1;
        expect_ev(8'hE1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        drain();
        checks++;
        if (ctrl_h !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL pause got ctrl=%b pending=%0d required 0/0", ctrl_h, sb.size());
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_ev(codes[i], 1'b0, 1'b0);
            send_byte(codes[i]);
        end
        cycles(2);
        checks++;
        if (ev_code !== 8'h15 || ovf !== 1'b0) begin
            errors++; $display("FAIL full_head got code=%h ovf=%b required 15/0", ev_code, ovf);
        end
        expect_ev(codes[4], 1'b0, 1'b0);
        send_byte(codes[4]);
        ready = 1'b1;
        drain();
        checks++;
        if (ovf !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL push_pop_full got ovf=%b pending=%0d required 0/0", ovf, sb.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32};
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_ev(codes[i], 1'b0, 1'b0);
            send_byte(codes[i]);
        end
        cycles(2);
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_early got ovf=%b required 0", ovf);
        end
        send_byte(codes[4]);
        cycles(2);
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set got ovf=%b required 1", ovf);
        end
        cycles(5);
        checks++;
        if ({ev_valid, ev_code} !== {1'b1, 8'h1A}) begin
            errors++; $display("FAIL head_hold got valid=%b code=%h required 1/1a", ev_valid, ev_code);
        end
        drain();
        checks++;
        if (ovf !== 1'b1 || sb.size() != 0) begin
            errors++; $display("FAIL ovf_sticky got ovf=%b pending=%0d required 1/0", ovf, sb.size());
        end
    endtask

    task automatic test_timeout();
        ready = 1'b1;
        send_byte(8'hE0);
        cycles(TO + 8);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL timeout_abandon got %0d pending required 0", sb.size());
        end
        send_byte(8'hE0);
        cycles(TO / 2);
        expect_ev(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL timeout_within got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_resp();
        ready = 1'b1;
        send_byte(8'hFA);
        checks++;
        if (resp !== 1'b1) begin
            errors++; $display("FAIL resp_fa got resp=%b required 1", resp);
        end
        cycles(1);
        checks++;
        if (resp !== 1'b0) begin
            errors++; $display("FAIL resp_pulse got resp=%b required 0", resp);
        end
        send_byte(8'h00);
        checks++;
        if (resp !== 1'b1) begin
            errors++; $display("FAIL resp_00 got resp=%b required 1", resp);
        end
        cycles(3);
        checks++;
        if (ev_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL resp_no_event got valid=%b required 0", ev_valid);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        send_byte(8'h12);
        send_byte(8'hF0);
        cycles(2);
        checks++;
        if (shift_h !== 1'b1 || ev_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset got shift=%b valid=%b required 1/1", shift_h, ev_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({ev_valid, ev_code, ev_ext, ev_rel, shift_h, ctrl_h, alt_h, ovf, resp} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h required 0000",
                     {ev_valid, ev_code, ev_ext, ev_rel, shift_h, ctrl_h, alt_h, ovf, resp});
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL after_reset got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_typematic();
        ready = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b1);
`else
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b1);
`endif
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL typematic got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_modifiers();
        test_pause();
        test_full_push_pop();
        test_overflow();
        test_timeout();
        test_resp();
        test_reset_mid();
        test_typematic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
